// File: rtl/router_ingress.sv
// Router ingress controller: parses a header/payload/parity byte stream and steers
// it into one of three destination FIFOs, checking even (XOR) parity on the way.
module router_ingress #(
  parameter logic [1:0] INVALID_ADDR = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_rst,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic [7:0] data_out,
  output logic       err
);

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    WRITE_HEADER,
    LOAD_DATA,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] rx_parity_q, rx_parity_d;
  logic       err_q, err_d;

  logic [2:0] addr_oh;
  logic [2:0] in_oh;
  logic       sel_full;
  logic       sel_soft;
  logic       in_empty;
  logic       in_drop;

  // Address 3 never has a FIFO, so it is dropped even if INVALID_ADDR is overridden.
  function automatic logic [2:0] dest_onehot(input logic [1:0] a);
    logic [2:0] oh;
    case (a)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign addr_oh  = dest_onehot(hdr_q[1:0]);
  assign in_oh    = dest_onehot(data_in[1:0]);
  assign sel_full = |(fifo_full & addr_oh);
  assign sel_soft = (state_q != DECODE) && (|(soft_rst & addr_oh));
  assign in_empty = |(fifo_empty & in_oh);
  assign in_drop  = (data_in[1:0] == INVALID_ADDR) || (in_oh == 3'b000);

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    parity_d    = parity_q;
    rx_parity_d = rx_parity_q;
    err_d       = err_q;
    busy        = 1'b0;
    write_enb   = 3'b000;
    lfd_state   = 1'b0;
    data_out    = 8'h00;

    case (state_q)
      DECODE: begin
        if (pkt_valid) begin
          hdr_d    = data_in;
          parity_d = data_in;
          err_d    = 1'b0;
          if (in_drop)       state_d = DROP;
          else if (in_empty) state_d = LOAD_FIRST;
          else               state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (|(fifo_empty & addr_oh)) state_d = LOAD_FIRST;
      end
      LOAD_FIRST: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        state_d   = WRITE_HEADER;
      end
      WRITE_HEADER: begin
        busy      = 1'b1;
        write_enb = addr_oh;
        data_out  = hdr_q;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        // A full FIFO stalls the source; the held byte is taken once full clears.
        busy = sel_full;
        if (!sel_full) begin
          write_enb = addr_oh;
          data_out  = data_in;
          if (pkt_valid) begin
            parity_d = parity_acc(parity_q, data_in);
          end else begin
            rx_parity_d = data_in;
            state_d     = CHECK_PARITY;
          end
        end
      end
      CHECK_PARITY: begin
        busy    = 1'b1;
        err_d   = (parity_q != rx_parity_q);
        state_d = DECODE;
      end
      DROP: begin
        if (!pkt_valid) state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase

    if (sel_soft) begin
      state_d     = DECODE;
      write_enb   = 3'b000;
      data_out    = 8'h00;
      lfd_state   = 1'b0;
      parity_d    = 8'h00;
      rx_parity_d = rx_parity_q;
      err_d       = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DECODE;
      hdr_q       <= 8'h00;
      parity_q    <= 8'h00;
      rx_parity_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      parity_q    <= parity_d;
      rx_parity_q <= rx_parity_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;

endmodule
